// File: rtl/vga_vram_arbiter.sv
// Shares a single-port VRAM between 4x-upscaled 160x120 scanout, a writer port and a fill engine.
// Optional writer stall counter is built when VRAM_STALL_CNT_EN is defined.
module vga_vram_arbiter #(
    parameter int HBP  = 144,
    parameter int HFP  = 784,
    parameter int VBP  = 31,
    parameter int VFP  = 511,
    parameter int FB_W = 160,
    parameter int FB_H = 120,
    parameter int AW   = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [9:0]    hc,
    input  logic [9:0]    vc,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [11:0]   wr_data,
    input  logic          clr_start,
    input  logic [11:0]   clr_color,
    output logic          clr_busy,
    output logic          clr_done,
    output logic [AW-1:0] vram_addr,
    output logic          vram_we,
    output logic [11:0]   vram_wdata,
    input  logic [11:0]   vram_rdata,
    output logic [3:0]    red,
    output logic [3:0]    green,
    output logic [3:0]    blue,
    output logic [15:0]   stall_cnt
);
    localparam logic [AW-1:0] FB_WORDS = AW'(FB_W * FB_H);
    localparam logic [AW-1:0] LAST_WORD = AW'(FB_W * FB_H - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] clr_ptr_reg;
    logic [11:0]   clr_color_reg;
    logic [11:0]   pixel_reg;

    logic [9:0]    hoff, voff, xw, yw;
    logic          v_act, h_act, scan_slot, capture;
    logic [AW-1:0] scan_addr;

    // Reads are issued two clocks ahead of the pixel so the registered RAM data lines up with hc.
    assign hoff      = hc - 10'(HBP - 2);
    assign voff      = vc - 10'(VBP);
    assign xw        = hoff >> 2;
    assign yw        = voff >> 2;
    assign v_act     = (vc >= 10'(VBP)) && (vc < 10'(VFP));
    assign h_act     = (hc >= 10'(HBP)) && (hc < 10'(HFP));
    assign scan_slot = v_act && (hc >= 10'(HBP - 2)) && (hc < 10'(HFP - 2)) && (hoff[1:0] == 2'd0);
    assign capture   = v_act && (hc >= 10'(HBP - 1)) && (hc < 10'(HFP - 1)) && (hoff[1:0] == 2'd1);
    assign scan_addr = (AW'(yw) << 7) + (AW'(yw) << 5) + AW'(xw);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_ptr_reg   <= '0;
            clr_color_reg <= 12'h000;
            pixel_reg     <= 12'h000;
        end else begin
            if (state_reg == IDLE && clr_start) begin
                clr_ptr_reg   <= '0;
                clr_color_reg <= clr_color;
            end else if (state_reg == CLEAR && !scan_slot) begin
                clr_ptr_reg <= clr_ptr_reg + 1'b1;
            end
            if (capture) begin
                pixel_reg <= vram_rdata;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (clr_start) state_next = CLEAR;
            CLEAR:   if (!scan_slot && clr_ptr_reg == LAST_WORD) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_ready   = 1'b0;
        vram_we    = 1'b0;
        vram_addr  = '0;
        vram_wdata = 12'h000;
        clr_busy   = rst_n && (state_reg == CLEAR);
        clr_done   = rst_n && (state_reg == DONE);
        if (rst_n) begin
            if (scan_slot) begin
                vram_addr = scan_addr;
            end else if (state_reg == CLEAR) begin
                vram_we    = 1'b1;
                vram_addr  = clr_ptr_reg;
                vram_wdata = clr_color_reg;
            end else if (state_reg == IDLE) begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    // Out-of-range writes still handshake but never reach the RAM.
                    vram_we    = (wr_addr < FB_WORDS);
                    vram_addr  = wr_addr;
                    vram_wdata = wr_data;
                end
            end
        end
    end

    assign {red, green, blue} = (rst_n && h_act && v_act) ? pixel_reg : 12'h000;

`ifdef VRAM_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_reg <= 16'h0000;
        end else if (wr_valid && !wr_ready && stall_cnt_reg != 16'hFFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Randomised and directed bench for vga_vram_arbiter with a framebuffer-level reference model.
module tb_vga_vram_arbiter;
    logic        clk;
    logic        rst_n;
    logic [9:0]  hc, vc;
    logic        wr_valid, wr_ready;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        clr_start;
    logic [11:0] clr_color;
    logic        clr_busy, clr_done;
    logic [14:0] vram_addr;
    logic        vram_we;
    logic [11:0] vram_wdata, vram_rdata;
    logic [3:0]  red, green, blue;
    logic [15:0] stall_cnt;

    vga_vram_arbiter dut (
        .clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
        .red(red), .green(green), .blue(blue), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment RAM with one-cycle registered read.
    logic [11:0] mem [0:32767];
    always @(posedge clk) begin
        if (vram_we) mem[vram_addr] <= vram_wdata;
        vram_rdata <= mem[vram_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad < 40) $display("FAIL %s: got %0h, expected %0h (hc=%0d vc=%0d t=%0t)", name, act, exp, hc, vc, $time);
        end
    endfunction

    // Reference model: framebuffer contents, clear progress, a per-line buffer of words read for scanout.
    logic [11:0] fb [0:19199];
    int          clear_left = 0;
    bit          done_pend = 0;
    logic [11:0] clr_col_m = 12'h000;
    logic [15:0] stall_m = 16'h0000;
    int          gen = 0;
    logic [11:0] lb_val [0:159];
    int          lb_vc [0:159];
    int          lb_gen [0:159];

    bit          m_scan, m_ready, m_we, m_act;
    int          m_addr, m_h, m_v, m_x;
    logic [11:0] m_wd;

    always @(negedge clk) begin
        m_h = int'(hc);
        m_v = int'(vc);
        m_scan = (m_v >= 31) && (m_v < 511) && (m_h >= 142) && (m_h < 782) && ((m_h - 142) % 4 == 0);
        m_ready = 0; m_we = 0; m_addr = 0; m_wd = 12'h000;
        if (rst_n) begin
            if (m_scan) begin
                m_addr = ((m_v - 31) / 4) * 160 + (m_h - 142) / 4;
            end else if (clear_left > 0) begin
                m_we = 1; m_addr = 19200 - clear_left; m_wd = clr_col_m;
            end else if (!done_pend) begin
                m_ready = 1;
                if (wr_valid && int'(wr_addr) < 19200) begin
                    m_we = 1; m_addr = int'(wr_addr); m_wd = wr_data;
                end
            end
        end
        chk("wr_ready", int'(wr_ready), int'(m_ready));
        chk("vram_we", int'(vram_we), int'(m_we));
        if (m_we || m_scan || !rst_n) chk("vram_addr", int'(vram_addr), m_addr);
        if (m_we || !rst_n) chk("vram_wdata", int'(vram_wdata), int'(m_wd));
        chk("clr_busy", int'(clr_busy), int'(rst_n && clear_left > 0));
        chk("clr_done", int'(clr_done), int'(rst_n && done_pend));
`ifdef VRAM_STALL_CNT_EN
        chk("stall_cnt", int'(stall_cnt), int'(rst_n ? stall_m : 16'h0000));
`else
        chk("stall_cnt", int'(stall_cnt), 0);
`endif
        m_act = rst_n && (m_v >= 31) && (m_v < 511) && (m_h >= 144) && (m_h < 784);
        if (!m_act) begin
            chk("rgb_blank", int'({red, green, blue}), 0);
        end else begin
            m_x = (m_h - 144) / 4;
            if (lb_vc[m_x] == m_v && lb_gen[m_x] == gen) chk("rgb", int'({red, green, blue}), int'(lb_val[m_x]));
        end
        // Advance the model across the coming clock edge.
        if (!rst_n) begin
            clear_left = 0; done_pend = 0; stall_m = 16'h0000;
        end else begin
            if (m_scan) begin
                m_x = (m_h - 142) / 4;
                lb_val[m_x] = fb[m_addr]; lb_vc[m_x] = m_v; lb_gen[m_x] = gen;
            end
            if (m_we) fb[m_addr] = m_wd;
            if (wr_valid && !m_ready && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
            if (done_pend) begin
                done_pend = 0;
            end else if (clear_left > 0) begin
                if (!m_scan) begin
                    clear_left--;
                    if (clear_left == 0) done_pend = 1;
                end
            end else if (clr_start) begin
                clear_left = 19200; clr_col_m = clr_color;
            end
        end
    end

    bit tg_run = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
        if (tg_run) begin
            if (hc == 10'd799) begin
                hc = 10'd0;
                vc = (vc == 10'd520) ? 10'd0 : vc + 10'd1;
            end else begin
                hc = hc + 10'd1;
            end
        end
    endtask

    task automatic set_pos(input int h, input int v);
        hc = 10'(h); vc = 10'(v); gen++;
    endtask

    int stalls, clr_writes, dones, bad_words, t;
    bit ok;

    initial begin
        for (int i = 0; i < 160; i++) begin lb_vc[i] = -1; lb_gen[i] = -1; lb_val[i] = 12'h000; end
        for (int i = 0; i < 32768; i++) begin
            logic [31:0] r;
            r = $urandom;
            mem[i] <= r[11:0];
            if (i < 19200) fb[i] = r[11:0];
        end
        mem[0] <= 12'hF00; fb[0] = 12'hF00;
        mem[1] <= 12'h0F0; fb[1] = 12'h0F0;
        rst_n = 1'b0; hc = 10'd200; vc = 10'd0;
        wr_valid = 1'b0; wr_addr = 15'd0; wr_data = 12'h000; clr_start = 1'b0; clr_color = 12'h000;

        // Reset held three clocks.
        repeat (3) begin
            cyc(); #1;
            chk("reset_wr_ready", int'(wr_ready), 0);
            chk("reset_we_addr", int'({vram_we, vram_addr}), 0);
            chk("reset_rgb", int'({red, green, blue}), 0);
        end
        rst_n = 1'b1; gen++;
        $display("reset: done");

        // First active line: two words read and shown four pixels each.
        set_pos(140, 31); tg_run = 1;
        while (hc != 10'd152) begin
            cyc(); #1;
            if (hc == 10'd142) chk("read_addr0", int'({vram_we, vram_addr}), 0);
            if (hc == 10'd146) chk("read_addr1", int'({vram_we, vram_addr}), 1);
            if (hc >= 10'd144 && hc <= 10'd147) chk("red_px", int'({red, green, blue}), 12'hF00);
            if (hc >= 10'd148 && hc <= 10'd151) chk("green_px", int'({red, green, blue}), 12'h0F0);
        end
        $display("scan: first two words shown");

        // Writer held through an active line.
        set_pos(130, 100); wr_valid = 1'b1; stalls = 0; ok = 1;
        while (hc != 10'd790) begin
            wr_addr = 15'($urandom_range(0, 19199)); wr_data = 12'($urandom);
            #1;
            if (!wr_ready) begin
                if (hc >= 10'd142 && hc < 10'd782 && hc[1:0] == 2'd2) stalls++; else ok = 0;
            end
`ifdef VRAM_STALL_CNT_EN
            if (hc == 10'd179) chk("stall_10", int'(stall_cnt), 10);
`endif
            cyc();
        end
        chk("stall_slots", stalls, 160);
        chk("stall_pattern", int'(ok), 1);
        $display("writer line: %0d stalled cycles", stalls);

        // Range boundary during vblank.
        set_pos(0, 515); wr_addr = 15'd19200; wr_data = 12'h555; #1;
        chk("oob_ready", int'(wr_ready), 1);
        chk("oob_we", int'(vram_we), 0);
        $display("write 19200: dropped");
        cyc(); wr_addr = 15'd19199; wr_data = 12'hABC; #1;
        chk("last_we", int'(vram_we), 1);
        chk("last_addr", int'(vram_addr), 19199);
        chk("last_data", int'(vram_wdata), 12'hABC);
        $display("write 19199 <= abc");
        cyc(); wr_valid = 1'b0;

        // Full clear; writer granted on the start cycle, a second start ignored.
        set_pos(0, 505); wr_valid = 1'b1; wr_addr = 15'd5; wr_data = 12'h123;
        clr_start = 1'b1; clr_color = 12'h00F; #1;
        chk("clr_start_grant", int'(wr_ready), 1);
        cyc(); clr_start = 1'b0;
        clr_writes = 0; dones = 0; t = 0;
        while (t < 25000) begin
            wr_valid = 1'($urandom); wr_addr = 15'($urandom_range(0, 19199)); wr_data = 12'($urandom);
            clr_start = (t == 100); clr_color = 12'hF00;
            #1;
            if (vram_we && clr_busy && vram_wdata == 12'h00F) clr_writes++;
            if (clr_done) begin dones++; wr_valid = 1'b0; clr_start = 1'b0; break; end
            cyc(); t++;
        end
        chk("clr_timeout", int'(t < 25000), 1);
        repeat (5) begin cyc(); #1; if (clr_done) dones++; end
        chk("clr_writes", clr_writes, 19200);
        chk("clr_done_pulses", dones, 1);
        bad_words = 0;
        for (int i = 0; i < 19200; i++) if (mem[i] != 12'h00F) bad_words++;
        chk("clr_contents", bad_words, 0);
        $display("clear: %0d writes, %0d done pulses", clr_writes, dones);

        // Reset during a clear aborts it silently.
        clr_start = 1'b1; clr_color = 12'h0F0; cyc(); clr_start = 1'b0;
        repeat (40) cyc();
        rst_n = 1'b0; gen++;
        repeat (2) cyc();
        #1; chk("abort_busy", int'(clr_busy), 0);
        rst_n = 1'b1; gen++; dones = 0;
        repeat (40) begin cyc(); #1; if (clr_done || clr_busy) dones++; end
        chk("abort_no_done", dones, 0);
        $display("clear aborted by reset");

        // Randomised traffic across active and blanking regions.
        set_pos(700, 60);
        for (int i = 0; i < 6000; i++) begin
            wr_valid = 1'($urandom);
            wr_addr = 15'($urandom_range(0, 19400));
            wr_data = 12'($urandom);
            clr_start = ($urandom_range(0, 2999) == 0);
            clr_color = 12'($urandom);
            cyc();
        end
        clr_start = 1'b0; wr_valid = 1'b0;

`ifdef VRAM_STALL_CNT_EN
        // Counter saturation.
        set_pos(130, 300); wr_valid = 1'b1;
        force dut.stall_cnt_reg = 16'hFFFF;
        #1 release dut.stall_cnt_reg;
        stall_m = 16'hFFFF;
        repeat (60) cyc();
        #1; chk("stall_sat", int'(stall_cnt), 16'hFFFF);
        wr_valid = 1'b0;
`endif
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
